// File: rtl/fetch_queue_if.sv
// Fetch-to-decode queue handshake bundle: valid/ready push port, valid/ready pop port, flush and occupancy.
interface fetch_queue_if #(
  parameter int DEPTH = 4,
  parameter int IW    = 32,
  parameter int AW    = 32
);
  logic                       in_valid;
  logic                       in_ready;
  logic [AW-1:0]              in_pc;
  logic [IW-1:0]              in_instr;
  logic                       flush;
  logic                       out_valid;
  logic                       out_ready;
  logic [AW-1:0]              out_pc;
  logic [IW-1:0]              out_instr;
  logic [$clog2(DEPTH):0]     count;

  // Queue side
  modport slave (
    input  in_valid, in_pc, in_instr, flush, out_ready,
    output in_ready, out_valid, out_pc, out_instr, count
  );

  // Fetch/decode side
  modport master (
    output in_valid, in_pc, in_instr, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, count
  );
endinterface

// File: rtl/fetch_queue.sv
// {pc, instr} queue between fetch and decode; 1-cycle minimum latency, no bypass.
// in_ready = not full (registered state only); flush empties the queue and overrides push/pop.
module fetch_queue #(
  parameter int          DEPTH = 4,
  parameter int          IW    = 32,
  parameter int          AW    = 32,
  parameter logic [IW-1:0] NOP = 32'h00000000
) (
  input logic            clk,
  input logic            rst_n,
  fetch_queue_if.slave   q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  entry_t        head;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign push  = q.in_valid & ~full;
  assign pop   = ~empty & q.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (q.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is deliberately unreset; only written on an accepted push, so X data with in_valid=0 is harmless.
  always_ff @(posedge clk) begin
    if (push && !q.flush) mem[wr_ptr] <= '{pc: q.in_pc, instr: q.in_instr};
  end

  assign head        = mem[rd_ptr];
  assign q.in_ready  = ~full;
  assign q.out_valid = ~empty;
  assign q.out_pc    = empty ? '0  : head.pc;
  assign q.out_instr = empty ? NOP : head.instr;
  assign q.count     = cnt;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, fill/drain, wrap, full push+pop, flush, latency.
module tb_fetch_queue;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  fetch_queue_if #(.DEPTH(4), .IW(32), .AW(32)) q ();

  fetch_queue #(.DEPTH(4), .IW(32), .AW(32), .NOP(32'h00000000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n       = 1'b0;
    q.in_valid  = 1'b0;
    q.in_pc     = 'x;
    q.in_instr  = 'x;
    q.flush     = 1'b0;
    q.out_ready = 1'b0;

    // Reset values
    #12;
    check("rst_out_valid", q.out_valid, 0);
    check("rst_count", q.count, 0);
    check("rst_out_instr", q.out_instr, 0);
    check("rst_out_pc", q.out_pc, 0);

    // Traffic, then asynchronous reset mid-cycle
    rst_n = 1'b1;
    tick();
    q.in_valid = 1'b1; q.in_pc = 32'h100; q.in_instr = 32'hAAAA0001;
    tick();
    q.in_pc = 32'h104; q.in_instr = 32'hAAAA0002;
    tick();
    check("traffic_count", q.count, 2);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", q.out_valid, 0);
    check("async_rst_count", q.count, 0);
    check("async_rst_out_instr", q.out_instr, 0);
    q.in_valid = 1'b0; q.in_pc = 'x; q.in_instr = 'x;
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", q.in_ready, 1);
    check("post_rst_count", q.count, 0);

    // Fill to full with decode stalled
    q.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      q.in_valid = 1'b1; q.in_pc = 32'(4 * i); q.in_instr = 32'h1000 + 32'(i);
      tick();
    end
    check("fill_count", q.count, 4);
    check("fill_in_ready", q.in_ready, 0);
    q.in_pc = 32'd16; q.in_instr = 32'h1004;
    tick();
    check("fifth_push_count", q.count, 4);
    check("fifth_push_head_pc", q.out_pc, 0);

    // Drain in order
    q.in_valid = 1'b0; q.in_pc = 'x; q.in_instr = 'x;
    q.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", q.out_valid, 1);
      check("drain_pc", q.out_pc, 64'(4 * i));
      check("drain_instr", q.out_instr, 64'h1000 + 64'(i));
      tick();
    end
    check("drained_out_valid", q.out_valid, 0);
    check("drained_out_instr", q.out_instr, 0);
    check("drained_count", q.count, 0);

    // Streaming push/pop pairs across pointer wrap
    for (int k = 0; k < 10; k++) begin
      q.in_valid = 1'b1; q.in_pc = 32'(4 * k); q.in_instr = 32'h2000 + 32'(k);
      #1;
      if (k > 0) begin
        check("wrap_pc", q.out_pc, 64'(4 * (k - 1)));
        check("wrap_instr", q.out_instr, 64'h2000 + 64'(k - 1));
      end
      check("wrap_count", q.count, (k > 0) ? 1 : 0);
      tick();
    end
    q.in_valid = 1'b0; q.in_pc = 'x; q.in_instr = 'x;
    #1;
    check("wrap_last_pc", q.out_pc, 36);
    check("wrap_last_count", q.count, 1);
    tick();
    check("wrap_empty", q.out_valid, 0);

    // Full with simultaneous push and pop
    q.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      q.in_valid = 1'b1; q.in_pc = 32'h40 + 32'(4 * i); q.in_instr = 32'h4000 + 32'(i);
      tick();
    end
    check("full_count", q.count, 4);
    q.in_pc = 32'h99; q.in_instr = 32'h9999; q.out_ready = 1'b1;
    #1;
    check("full_in_ready_low", q.in_ready, 0);
    tick();
    check("full_pop_count", q.count, 3);
    check("full_pop_in_ready", q.in_ready, 1);
    check("full_pop_head_pc", q.out_pc, 64'h44);

    // Flush with push and pop attempts in the same cycle
    q.in_valid = 1'b1; q.in_pc = 32'h77; q.in_instr = 32'h7777; q.out_ready = 1'b1;
    q.flush = 1'b1;
    tick();
    q.flush = 1'b0; q.in_valid = 1'b0; q.in_pc = 'x; q.in_instr = 'x; q.out_ready = 1'b0;
    #1;
    check("flush_count", q.count, 0);
    check("flush_out_valid", q.out_valid, 0);
    check("flush_out_instr", q.out_instr, 0);
    q.in_valid = 1'b1; q.in_pc = 32'h80; q.in_instr = 32'h3000;
    tick();
    q.in_valid = 1'b0; q.in_pc = 'x; q.in_instr = 'x;
    #1;
    check("post_flush_pc", q.out_pc, 64'h80);
    check("post_flush_instr", q.out_instr, 64'h3000);
    check("post_flush_count", q.count, 1);
    q.out_ready = 1'b1;
    tick();
    q.out_ready = 1'b0;
    check("post_flush_drained", q.out_valid, 0);

    // Single-entry latency: not visible before the pushing edge
    q.in_valid = 1'b1; q.in_pc = 32'h200; q.in_instr = 32'h8C010004;
    #1;
    check("lat_before_valid", q.out_valid, 0);
    check("lat_before_instr", q.out_instr, 0);
    tick();
    q.in_valid = 1'b0; q.in_pc = 'x; q.in_instr = 'x;
    check("lat_after_valid", q.out_valid, 1);
    check("lat_after_instr", q.out_instr, 64'h8C010004);
    check("lat_after_pc", q.out_pc, 64'h200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
